qtree_cfg_ctrl: RTL and testbench
=================================

Name: qtree_cfg_ctrl

Overview:
- Sequences table updates into the quadtree lookup pipeline: owns lookup ingress to level 0 and the per-level mm_ram write ports of every qtree level.
- On an update request it blocks new lookups, drains the in-flight count to zero, writes a burst of key triplets into the selected level RAMs, then resumes lookups.
- Lookups therefore never observe a partially updated tree.

Parameters:
- LEVEL_CNT, 4, number of qtree levels driven (write-enable vector width).
- KEY_WIDTH, 16, key width; RAM word = 3*KEY_WIDTH (l, m, r).
- RAM_ADDR_WIDTH, 8, widest level RAM address; narrower levels use LSBs.
- DATA_WIDTH, 16, lookup payload width (level_data_t).
- BYPASS_WIDTH, 1, lookup bypass width.
- INFLIGHT_WIDTH, 6, in-flight counter width; must hold max pipeline depth.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- lookup_data_i  in  DATA_WIDTH  lookup request payload
- lookup_bypass_i  in  BYPASS_WIDTH  lookup bypass
- lookup_valid_i  in  1  lookup request valid
- lookup_ready_o  out  1  lookup accepted when valid&ready
- pipe_data_o  out  DATA_WIDTH  to level 0 in_data_i
- pipe_bypass_o  out  BYPASS_WIDTH  to level 0 in_bypass_i
- pipe_valid_o  out  1  to level 0 in_valid_i
- pipe_done_i  in  1  last-level out_valid_o (one result retired)
- upd_level_i  in  $clog2(LEVEL_CNT)  target level
- upd_addr_i  in  RAM_ADDR_WIDTH  target RAM address
- upd_data_i  in  3*KEY_WIDTH  key triplet
- upd_last_i  in  1  last beat of burst
- upd_valid_i  in  1  update beat valid
- upd_ready_o  out  1  update beat accepted when valid&ready
- mm_ram_data_o  out  3*KEY_WIDTH  shared write data to all levels
- mm_ram_addr_o  out  RAM_ADDR_WIDTH  shared write address
- mm_ram_write_o  out  LEVEL_CNT  one-hot per-level write enable
- busy_o  out  1  state != IDLE
- err_o  out  1  sticky: pipe_done_i seen with in-flight count 0

Behaviour:
- Reset (async): state=IDLE, inflight=0, pipe_valid_o=0, mm_ram_write_o=0, upd_ready_o=0, err_o=0, busy_o=0; pipe_data_o/bypass, mm data/addr = 0.
- FSM states: IDLE, DRAIN, WRITE, SETTLE.
- IDLE: lookup_ready_o=1 unless upd_valid_i=1 (updates have priority; an update request blocks acceptance in the same cycle). upd_valid_i=1 -> DRAIN.
- DRAIN: lookup_ready_o=0, upd_ready_o=0. inflight==0 -> WRITE (same cycle as count reaches 0 observed registered; minimum one cycle in DRAIN).
- WRITE: lookup_ready_o=0, upd_ready_o=1. Each accepted beat registers mm_ram_addr_o/data_o and sets mm_ram_write_o[upd_level_i] for exactly one cycle (latency 1). Accepted beat with upd_last_i=1 -> SETTLE. Gaps (upd_valid_i=0) stay in WRITE, no writes.
- upd_level_i >= LEVEL_CNT: beat is accepted, no write bit set, err_o set.
- SETTLE: one cycle, no accepts, lets the last write commit before any read; -> IDLE.
- Lookup path: accepted lookup registers into pipe_data_o/bypass with pipe_valid_o=1 next cycle (latency 1); otherwise pipe_valid_o=0.
- Inflight counter: +1 on pipe_valid_o, -1 on pipe_done_i, unchanged on both. Decrement at 0 saturates at 0 and sets err_o. Increment at all-ones saturates and sets err_o.
- Cleared only by reset: err_o.
- Reset mid-burst: all state lost; the update source restarts the burst from beat 0.

Optional Feature:
- QTREE_CFG_CTRL_STATS_EN defined: adds outputs stat_upd_cnt_o (32b, accepted update beats) and stat_stall_cnt_o (32b, cycles with lookup_valid_i=1 and lookup_ready_o=0). Both wrap at 2^32 and reset to 0.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Idle lookups: 5 back-to-back lookups, no updates -> pipe_valid_o high 5 cycles starting 1 cycle after the first accept; inflight=5; 5 pipe_done_i pulses -> inflight=0.
- Drain: 3 lookups in flight, then upd burst of 2 beats (level 1 addr 0x03, level 2 addr 0x0C) -> lookup_ready_o=0 immediately; upd_ready_o stays 0 until the third pipe_done_i; mm_ram_write_o=4'b0010 then 4'b0100 with the matching addr/data.
- Priority: lookup_valid_i and upd_valid_i rise in the same IDLE cycle with inflight=0 -> lookup not accepted; DRAIN 1 cycle; WRITE; after last beat, SETTLE 1 cycle; lookup accepted on the following cycle.
- Burst gaps: 3-beat burst with upd_valid_i low 2 cycles between beats -> exactly 3 write pulses, state stays WRITE through the gaps, busy_o=1 throughout.
- Errors: pipe_done_i with inflight=0 -> err_o=1 and stays 1; upd_level_i=LEVEL_CNT -> mm_ram_write_o=0 and err_o=1.
- Async reset asserted mid-WRITE, between clock edges -> all outputs immediately at reset values; state=IDLE after release.

Source files
------------

// File: rtl/qtree_cfg_ctrl.sv
// Quadtree table-update sequencer: gates lookup ingress, drains the pipeline, then bursts key triplets
// into the per-level RAMs. Optional statistics counters are built when QTREE_CFG_CTRL_STATS_EN is defined.
module qtree_cfg_ctrl #(
  parameter int LEVEL_CNT      = 4,
  parameter int KEY_WIDTH      = 16,
  parameter int RAM_ADDR_WIDTH = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int BYPASS_WIDTH   = 1,
  parameter int INFLIGHT_WIDTH = 6
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [DATA_WIDTH-1:0]        lookup_data_i,
  input  logic [BYPASS_WIDTH-1:0]      lookup_bypass_i,
  input  logic                         lookup_valid_i,
  output logic                         lookup_ready_o,
  output logic [DATA_WIDTH-1:0]        pipe_data_o,
  output logic [BYPASS_WIDTH-1:0]      pipe_bypass_o,
  output logic                         pipe_valid_o,
  input  logic                         pipe_done_i,
  input  logic [$clog2(LEVEL_CNT)-1:0] upd_level_i,
  input  logic [RAM_ADDR_WIDTH-1:0]    upd_addr_i,
  input  logic [3*KEY_WIDTH-1:0]       upd_data_i,
  input  logic                         upd_last_i,
  input  logic                         upd_valid_i,
  output logic                         upd_ready_o,
  output logic [3*KEY_WIDTH-1:0]       mm_ram_data_o,
  output logic [RAM_ADDR_WIDTH-1:0]    mm_ram_addr_o,
  output logic [LEVEL_CNT-1:0]         mm_ram_write_o,
  output logic                         busy_o,
  output logic                         err_o
`ifdef QTREE_CFG_CTRL_STATS_EN
  ,
  output logic [31:0]                  stat_upd_cnt_o,
  output logic [31:0]                  stat_stall_cnt_o
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_SETTLE = 2'd3;

  logic [1:0]                state;
  logic [1:0]                state_nxt;
  logic [INFLIGHT_WIDTH-1:0] inflight;
  logic [INFLIGHT_WIDTH-1:0] inflight_nxt;
  logic                      cnt_err;
  logic                      lookup_acc;
  logic                      upd_acc;
  logic                      level_ok;
  logic [LEVEL_CNT-1:0]      wr_sel;

  // Update requests take priority: a pending beat closes the lookup gate in the same cycle.
  assign lookup_ready_o = (state == S_IDLE) && !upd_valid_i;
  assign upd_ready_o    = (state == S_WRITE);
  assign busy_o         = (state != S_IDLE);
  assign lookup_acc     = lookup_valid_i && lookup_ready_o;
  assign upd_acc        = upd_valid_i && upd_ready_o;
  assign level_ok       = (int'(upd_level_i) < LEVEL_CNT);

  always_comb begin
    wr_sel = '0;
    for (int unsigned i = 0; i < LEVEL_CNT; i++) begin
      if (32'(upd_level_i) == i) wr_sel[i] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (upd_valid_i) state_nxt = S_DRAIN;
      S_DRAIN:  if (inflight == '0) state_nxt = S_WRITE;
      S_WRITE:  if (upd_acc && upd_last_i) state_nxt = S_SETTLE;
      S_SETTLE: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Both saturation directions flag an accounting fault instead of wrapping.
  always_comb begin
    inflight_nxt = inflight;
    cnt_err      = 1'b0;
    case ({pipe_valid_o, pipe_done_i})
      2'b10: begin
        if (inflight == '1) cnt_err = 1'b1;
        else                inflight_nxt = inflight + INFLIGHT_WIDTH'(1);
      end
      2'b01: begin
        if (inflight == '0) cnt_err = 1'b1;
        else                inflight_nxt = inflight - INFLIGHT_WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      inflight <= '0;
      err_o    <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= inflight_nxt;
      if (cnt_err || (upd_acc && !level_ok)) err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_valid_o  <= 1'b0;
      pipe_data_o   <= '0;
      pipe_bypass_o <= '0;
    end else begin
      pipe_valid_o <= lookup_acc;
      if (lookup_acc) begin
        pipe_data_o   <= lookup_data_i;
        pipe_bypass_o <= lookup_bypass_i;
      end
    end
  end

  // Out-of-range levels still consume the beat; wr_sel is all-zero for them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mm_ram_write_o <= '0;
      mm_ram_addr_o  <= '0;
      mm_ram_data_o  <= '0;
    end else begin
      mm_ram_write_o <= upd_acc ? wr_sel : '0;
      if (upd_acc) begin
        mm_ram_addr_o <= upd_addr_i;
        mm_ram_data_o <= upd_data_i;
      end
    end
  end

`ifdef QTREE_CFG_CTRL_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_upd_cnt_o   <= '0;
      stat_stall_cnt_o <= '0;
    end else begin
      if (upd_acc) stat_upd_cnt_o <= stat_upd_cnt_o + 32'd1;
      if (lookup_valid_i && !lookup_ready_o) stat_stall_cnt_o <= stat_stall_cnt_o + 32'd1;
    end
  end
`else
  // Statistics counters not built.
`endif

endmodule

// File: tb/tb_qtree_cfg_ctrl.sv
// Directed bench for qtree_cfg_ctrl with scoreboard queues for lookup and RAM-write outputs.
module tb_qtree_cfg_ctrl;

  localparam int LC = 3;

  logic        clk;
  logic        rst;
  logic [15:0] lookup_data;
  logic [0:0]  lookup_bypass;
  logic        lookup_valid;
  logic        lookup_ready;
  logic [15:0] pipe_data;
  logic [0:0]  pipe_bypass;
  logic        pipe_valid;
  logic        pipe_done;
  logic [1:0]  upd_level;
  logic [7:0]  upd_addr;
  logic [47:0] upd_data;
  logic        upd_last;
  logic        upd_valid;
  logic        upd_ready;
  logic [47:0] mm_data;
  logic [7:0]  mm_addr;
  logic [2:0]  mm_write;
  logic        busy;
  logic        err;

  typedef struct {
    int          cyc;
    logic [15:0] d;
    logic        b;
  } pipe_exp_t;

  typedef struct {
    int          cyc;
    logic [2:0]  we;
    logic [7:0]  a;
    logic [47:0] d;
  } wr_exp_t;

  pipe_exp_t pq[$];
  wr_exp_t   wq[$];
  pipe_exp_t pe;
  wr_exp_t   we;
  int        n_vec;
  int        n_err;
  int        cyc;

  qtree_cfg_ctrl #(.LEVEL_CNT(LC)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .lookup_data_i  (lookup_data),
    .lookup_bypass_i(lookup_bypass),
    .lookup_valid_i (lookup_valid),
    .lookup_ready_o (lookup_ready),
    .pipe_data_o    (pipe_data),
    .pipe_bypass_o  (pipe_bypass),
    .pipe_valid_o   (pipe_valid),
    .pipe_done_i    (pipe_done),
    .upd_level_i    (upd_level),
    .upd_addr_i     (upd_addr),
    .upd_data_i     (upd_data),
    .upd_last_i     (upd_last),
    .upd_valid_i    (upd_valid),
    .upd_ready_o    (upd_ready),
    .mm_ram_data_o  (mm_data),
    .mm_ram_addr_o  (mm_addr),
    .mm_ram_write_o (mm_write),
    .busy_o         (busy),
    .err_o          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic lookup(input logic [15:0] d, input logic b);
    lookup_valid  = 1'b1;
    lookup_data   = d;
    lookup_bypass = b;
    #1;
    chk("lookup_ready", lookup_ready, 1);
    pq.push_back('{cyc: cyc + 1, d: d, b: b});
    tick;
  endtask

  task automatic set_upd(input logic [1:0] lvl, input logic [7:0] a, input logic [47:0] d, input logic last);
    upd_valid = 1'b1;
    upd_level = lvl;
    upd_addr  = a;
    upd_data  = d;
    upd_last  = last;
  endtask

  task automatic beat(input logic [1:0] lvl, input logic [7:0] a, input logic [47:0] d,
                      input logic last, input logic [2:0] we_exp);
    set_upd(lvl, a, d, last);
    #1;
    chk("upd_ready_write", upd_ready, 1);
    if (we_exp != 3'b000) wq.push_back('{cyc: cyc + 1, we: we_exp, a: a, d: d});
    tick;
  endtask

  task automatic gap_check;
    upd_valid = 1'b0;
    #1;
    chk("gap_busy", busy, 1);
    chk("gap_upd_ready", upd_ready, 1);
    tick;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (pipe_valid === 1'b1) begin
        if (pq.size() == 0) chk("pipe_unexpected", pipe_valid, 0);
        else begin
          pe = pq.pop_front();
          chk("pipe_cycle", cyc, pe.cyc);
          chk("pipe_data", pipe_data, pe.d);
          chk("pipe_bypass", pipe_bypass, pe.b);
        end
      end
      if (mm_write !== 3'b000) begin
        if (wq.size() == 0) chk("wr_unexpected", mm_write, 0);
        else begin
          we = wq.pop_front();
          chk("wr_cycle", cyc, we.cyc);
          chk("wr_enable", mm_write, we.we);
          chk("wr_addr", mm_addr, we.a);
          chk("wr_data", mm_data, we.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    rst = 1'b1;
    lookup_data = '0; lookup_bypass = '0; lookup_valid = 1'b0; pipe_done = 1'b0;
    upd_level = '0; upd_addr = '0; upd_data = '0; upd_last = 1'b0; upd_valid = 1'b0;
    tick; tick;
    chk("rst_pipe_valid", pipe_valid, 0);
    chk("rst_mm_write", mm_write, 0);
    chk("rst_upd_ready", upd_ready, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pipe_data", pipe_data, 0);
    chk("rst_mm_addr", mm_addr, 0);
    chk("rst_mm_data", mm_data, 0);
    chk("rst_lookup_ready", lookup_ready, 1);
    rst = 1'b0;
    tick;

    // Idle lookups: five back-to-back, then five retirements.
    for (int i = 0; i < 5; i++) lookup(16'($urandom), 1'($urandom));
    lookup_valid = 1'b0;
    tick;
    chk("idle_inflight5", dut.inflight, 5);
    chk("idle_pipe_valid_off", pipe_valid, 0);
    for (int i = 0; i < 5; i++) begin
      pipe_done = 1'b1;
      tick;
    end
    pipe_done = 1'b0;
    chk("idle_inflight0", dut.inflight, 0);
    chk("idle_err", err, 0);

    // Drain: three in flight, then a two-beat burst.
    for (int i = 0; i < 3; i++) lookup(16'($urandom), 1'($urandom));
    set_upd(2'd1, 8'h03, 48'h1111_2222_3333, 1'b0);
    #1;
    chk("drain_lookup_block", lookup_ready, 0);
    chk("drain_upd_ready0", upd_ready, 0);
    tick;
    chk("drain_busy", busy, 1);
    chk("drain_inflight3", dut.inflight, 3);
    for (int j = 0; j < 3; j++) begin
      chk("drain_upd_wait", upd_ready, 0);
      chk("drain_lookup_wait", lookup_ready, 0);
      pipe_done = 1'b1;
      tick;
    end
    pipe_done = 1'b0;
    chk("drain_last_cycle", upd_ready, 0);
    tick;
    beat(2'd1, 8'h03, 48'h1111_2222_3333, 1'b0, 3'b010);
    beat(2'd2, 8'h0C, 48'h4444_5555_6666, 1'b1, 3'b100);
    upd_valid = 1'b0;
    #1;
    chk("drain_settle_upd", upd_ready, 0);
    chk("drain_settle_busy", busy, 1);
    tick;
    lookup(16'hBEEF, 1'b1);
    lookup_valid = 1'b0;
    tick;
    pipe_done = 1'b1;
    tick;
    pipe_done = 1'b0;

    // Priority: lookup and update rise together with nothing in flight.
    lookup_valid = 1'b1;
    lookup_data  = 16'hCAFE;
    set_upd(2'd0, 8'h55, 48'hAAAA_BBBB_CCCC, 1'b1);
    #1;
    chk("prio_lookup_block", lookup_ready, 0);
    tick;
    chk("prio_drain_busy", busy, 1);
    chk("prio_drain_upd", upd_ready, 0);
    tick;
    beat(2'd0, 8'h55, 48'hAAAA_BBBB_CCCC, 1'b1, 3'b001);
    upd_valid = 1'b0;
    #1;
    chk("prio_settle_lookup", lookup_ready, 0);
    chk("prio_settle_busy", busy, 1);
    tick;
    lookup(16'hCAFE, 1'b0);
    lookup_valid = 1'b0;
    tick;
    pipe_done = 1'b1;
    tick;
    pipe_done = 1'b0;

    // Burst with two-cycle gaps between beats.
    set_upd(2'd2, 8'h10, 48'h0000_0000_0010, 1'b0);
    tick;
    tick;
    beat(2'd2, 8'h10, 48'h0000_0000_0010, 1'b0, 3'b100);
    gap_check; gap_check;
    beat(2'd0, 8'h11, 48'h0000_0000_0011, 1'b0, 3'b001);
    gap_check; gap_check;
    beat(2'd1, 8'h12, 48'h0000_0000_0012, 1'b1, 3'b010);
    upd_valid = 1'b0;
    tick;
    chk("gap_idle_busy", busy, 0);

    // Out-of-range level: beat consumed, no write strobe, error latched.
    chk("badlvl_err_before", err, 0);
    set_upd(2'd3, 8'h77, 48'hDEAD_0000_BEEF, 1'b1);
    tick;
    tick;
    beat(2'd3, 8'h77, 48'hDEAD_0000_BEEF, 1'b1, 3'b000);
    chk("badlvl_no_write", mm_write, 0);
    chk("badlvl_err", err, 1);
    upd_valid = 1'b0;
    tick;

    // Asynchronous reset between edges while a write pulse is active.
    set_upd(2'd1, 8'h21, 48'h0123_4567_89AB, 1'b0);
    tick;
    tick;
    beat(2'd1, 8'h21, 48'h0123_4567_89AB, 1'b0, 3'b010);
    set_upd(2'd2, 8'h22, 48'h0000_1111_2222, 1'b0);
    #5;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_upd_ready", upd_ready, 0);
    chk("arst_mm_write", mm_write, 0);
    chk("arst_mm_addr", mm_addr, 0);
    chk("arst_mm_data", mm_data, 0);
    chk("arst_err", err, 0);
    chk("arst_pipe_valid", pipe_valid, 0);
    chk("arst_pipe_data", pipe_data, 0);
    chk("arst_lookup_ready", lookup_ready, 0);
    upd_valid = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    chk("arst_idle_busy", busy, 0);
    chk("arst_idle_lookup", lookup_ready, 1);
    chk("arst_inflight", dut.inflight, 0);

    // Retirement with nothing in flight.
    chk("underflow_err_before", err, 0);
    pipe_done = 1'b1;
    tick;
    pipe_done = 1'b0;
    chk("underflow_err", err, 1);
    tick;
    tick;
    chk("underflow_err_sticky", err, 1);
    chk("underflow_inflight_sat", dut.inflight, 0);

    chk("pipe_queue_empty", pq.size(), 0);
    chk("wr_queue_empty", wq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
